dmem_responder: RTL

Data-side memory responder: the far end of the CPU's load/store port, rebuilt as a handshaked, multi-cycle memory instead of a zero-latency array. Accepts one request at a time over a valid/ready channel, performs the word access after a fixed parameterised latency, and returns a response over a second valid/ready channel. It sits between the MEM stage's request logic and the backing store, and lets the pipeline be exercised against realistic memory stalls.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word store: byte-strobed synchronous write, combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, fixed access latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [31:0]       req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    input  logic [STRB_W-1:0] req_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WORD_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;

    logic              lat_write;
    logic [31:0]       lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic [STRB_W-1:0] lat_wstrb;

    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              accept;
    logic              fire;
    logic              access_err;
    logic              mem_we;
    logic [AW-1:0]     word_idx;
    logic [WORD_W-1:0] mem_rdata;

    assign accept = (state == StIdle) && req_valid_i;
    assign fire   = (state == StBusy) && (cnt == '0);

    // Misaligned, or any address bit at or above DEPTH*4.
    assign access_err = (lat_addr[1:0] != 2'b00) || ((lat_addr >> (AW + 2)) != 32'd0);
    assign word_idx   = lat_addr[AW+1:2];
    assign mem_we     = fire && lat_write && !access_err;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            StIdle: begin
                if (req_valid_i) begin
                    state_nxt = StBusy;
                    cnt_nxt   = CW'(LATENCY - 1);
                end
            end
            StBusy: begin
                if (cnt == '0) begin
                    state_nxt = StResp;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_nxt = StIdle;
                end
            end
            default: state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= StIdle;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
        end else if (accept) begin
            lat_write <= req_write_i;
            lat_addr  <= req_addr_i;
            lat_wdata <= req_wdata_i;
            lat_wstrb <= req_wstrb_i;
        end
    end

    // Loads capture the pre-write word; stores and errors return zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (fire) begin
            rsp_err   <= access_err;
            rsp_rdata <= (access_err || lat_write) ? '0 : mem_rdata;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk_i),
        .we    (mem_we),
        .addr  (word_idx),
        .wdata (lat_wdata),
        .wstrb (lat_wstrb),
        .rdata (mem_rdata)
    );

    assign req_ready_o = (state == StIdle);
    assign rsp_valid_o = (state == StResp);
    assign rsp_rdata_o = rsp_rdata;
    assign rsp_err_o   = rsp_err;

endmodule
